// File: rtl/synth_pkg.sv
// Shared synth-control definitions: default data width, encoder start value
// and the glide state encoding.
package synth_pkg;

  localparam int unsigned GLIDE_WIDTH     = 15;
  localparam logic [14:0] GLIDE_RESET_VAL = 15'h2000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } glide_state_t;

endpackage

// File: rtl/glide_prescaler.sv
// Rate prescaler for param_glide: loadable down-counter that freezes while
// disabled and flags tick when it has counted down to zero.
module glide_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/param_glide.sv
// Parameter glide: slews a registered output toward the encoder target in
// programmable power-of-two steps at a prescaled rate, never passing the target.
module param_glide
  import synth_pkg::*;
#(
  parameter int unsigned      WIDTH     = GLIDE_WIDTH,
  parameter int unsigned      DIV_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(GLIDE_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] target_in,
  input  logic [DIV_W-1:0] rate_div,
  input  logic [3:0]       step_shift,
  input  logic             hold,
  output logic [WIDTH-1:0] value_out,
  output logic             upd_stb,
  output logic             busy,
  output logic             at_target
);

  glide_state_t     state_q, state_d;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] value_q, value_d;
  logic             upd_q, at_q;
  logic             presc_load, presc_tick;

  logic [3:0]       shift_eff;
  logic [WIDTH-1:0] step;
  logic [WIDTH:0]   diff, mag;
  logic             neg;

  glide_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (presc_load),
    .load_val (rate_div),
    .en       (~hold),
    .tick     (presc_tick)
  );

  always_comb begin
    shift_eff = (step_shift > 4'(WIDTH - 1)) ? 4'(WIDTH - 1) : step_shift;
    step      = {{(WIDTH-1){1'b0}}, 1'b1} << shift_eff;
    diff      = {1'b0, tgt_q} - {1'b0, value_q};
    neg       = diff[WIDTH];
    mag       = neg ? (~diff + 1'b1) : diff;
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    presc_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tgt_q != value_q) begin
          state_d    = ST_RAMP;
          presc_load = 1'b1;
        end
      end
      ST_RAMP: begin
        if (!hold && presc_tick) begin
          presc_load = 1'b1;
          // Snapping whenever the remaining distance fits in one step keeps
          // the output inside [0, 2^WIDTH-1] without any saturation logic.
          if (mag <= {1'b0, step}) begin
            value_d = tgt_q;
            state_d = ST_IDLE;
          end else if (neg) begin
            value_d = value_q - step;
          end else begin
            value_d = value_q + step;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // at_target is flopped from next-state values so it always equals
  // (value_out == tgt_q) for the current cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= RESET_VAL;
      value_q <= RESET_VAL;
      upd_q   <= 1'b0;
      at_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tgt_q   <= target_in;
      value_q <= value_d;
      upd_q   <= (value_d != value_q);
      at_q    <= (value_d == target_in);
    end
  end

  assign value_out = value_q;
  assign upd_stb   = upd_q;
  assign busy      = (state_q == ST_RAMP);
  assign at_target = at_q;

endmodule

// File: tb/tb_param_glide.sv
// Self-checking bench for param_glide: directed vector table with hand-derived
// expectations, plus randomized traffic against an integer reference model.
module tb_param_glide;

  logic        clk;
  logic        rst_n;
  logic [14:0] target_in;
  logic [15:0] rate_div;
  logic [3:0]  step_shift;
  logic        hold;
  logic [14:0] value_out;
  logic        upd_stb;
  logic        busy;
  logic        at_target;

  int checks   = 0;
  int failures = 0;

  param_glide #(
    .WIDTH     (15),
    .DIV_W     (16),
    .RESET_VAL (15'h2000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .target_in  (target_in),
    .rate_div   (rate_div),
    .step_shift (step_shift),
    .hold       (hold),
    .value_out  (value_out),
    .upd_stb    (upd_stb),
    .busy       (busy),
    .at_target  (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integers, one call per clock edge.
  int m_val, m_tgt, m_cnt;
  bit m_ramp, m_stb;

  task automatic model_reset();
    m_val  = 'h2000;
    m_tgt  = 'h2000;
    m_cnt  = 0;
    m_ramp = 1'b0;
    m_stb  = 1'b0;
  endtask

  task automatic model_clock(input int t, input int rd, input int ss, input bit h);
    int st, d, nv;
    m_stb = 1'b0;
    if (!m_ramp) begin
      if (m_tgt != m_val) begin
        m_ramp = 1'b1;
        m_cnt  = rd;
      end
    end else if (!h) begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
      end else begin
        st = 1 << ((ss > 14) ? 14 : ss);
        d  = m_tgt - m_val;
        if (d <= st && d >= -st) begin
          nv     = m_tgt;
          m_ramp = 1'b0;
        end else begin
          nv = (d > 0) ? m_val + st : m_val - st;
        end
        m_stb = (nv != m_val);
        m_val = nv;
        m_cnt = rd;
      end
    end
    m_tgt = t;
  endtask

  task automatic check_model(input string tag);
    logic [17:0] act, exp;
    act = {value_out, upd_stb, busy, at_target};
    exp = {m_val[14:0], m_stb, m_ramp, (m_val == m_tgt)};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got val=%h stb=%b busy=%b at=%b, want val=%h stb=%b busy=%b at=%b",
               tag, act[17:3], act[2], act[1], act[0], exp[17:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_clock(int'(target_in), int'(rate_div), int'(step_shift), hold);
    @(negedge clk);
    check_model(tag);
  endtask

  // Called from a negedge; reset is pulsed well clear of the next posedge.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    logic [14:0] tgt;
    logic [15:0] rd;
    logic [3:0]  ss;
    logic        h;
    int          n;
    logic [14:0] val;
    logic        bsy;
    logic        stb;
    logic        at;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, logic [14:0] tgt, logic [15:0] rd, logic [3:0] ss,
                              logic h, int n, logic [14:0] val, logic bsy, logic stb, logic at);
    vec_t v;
    v.rst = rst; v.tgt = tgt; v.rd = rd; v.ss = ss; v.h = h; v.n = n;
    v.val = val; v.bsy = bsy; v.stb = stb; v.at = at;
    return v;
  endfunction

  initial begin
    logic [17:0] act, exp;
    int          nv;

    rst_n      = 1'b0;
    target_in  = 15'h2000;
    rate_div   = '0;
    step_shift = 4'd3;
    hold       = 1'b0;
    model_reset();
    #12;
    @(negedge clk);

    checks++;
    if ({value_out, upd_stb, busy, at_target} !== {15'h2000, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: got val=%h stb=%b busy=%b at=%b, want 2000/0/0/1",
               value_out, upd_stb, busy, at_target);
    end
    rst_n = 1'b1;

    // idle at reset value
    vecs.push_back(mk(0, 15'h2000, 0, 3, 0, 10, 15'h2000, 0, 0, 1));
    // rate 0, step 8 up to 2020
    vecs.push_back(mk(0, 15'h2020, 0, 3, 0, 1, 15'h2000, 0, 0, 0));
    vecs.push_back(mk(0, 15'h2020, 0, 3, 0, 1, 15'h2000, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2020, 0, 3, 0, 1, 15'h2008, 1, 1, 0));
    vecs.push_back(mk(0, 15'h2020, 0, 3, 0, 1, 15'h2010, 1, 1, 0));
    vecs.push_back(mk(0, 15'h2020, 0, 3, 0, 1, 15'h2018, 1, 1, 0));
    vecs.push_back(mk(0, 15'h2020, 0, 3, 0, 1, 15'h2020, 0, 1, 1));
    vecs.push_back(mk(0, 15'h2020, 0, 3, 0, 1, 15'h2020, 0, 0, 1));
    // rate 4, step 0x100, final partial step snaps
    vecs.push_back(mk(1, 15'h2150, 4, 8, 0, 1, 15'h2000, 0, 0, 0));
    vecs.push_back(mk(0, 15'h2150, 4, 8, 0, 1, 15'h2000, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2150, 4, 8, 0, 4, 15'h2000, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2150, 4, 8, 0, 1, 15'h2100, 1, 1, 0));
    vecs.push_back(mk(0, 15'h2150, 4, 8, 0, 4, 15'h2100, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2150, 4, 8, 0, 1, 15'h2150, 0, 1, 1));
    vecs.push_back(mk(0, 15'h2150, 4, 8, 0, 1, 15'h2150, 0, 0, 1));
    // mid-ramp reversal
    vecs.push_back(mk(1, 15'h2100, 0, 3, 0, 1, 15'h2000, 0, 0, 0));
    vecs.push_back(mk(0, 15'h2100, 0, 3, 0, 1, 15'h2000, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2100, 0, 3, 0, 1, 15'h2008, 1, 1, 0));
    vecs.push_back(mk(0, 15'h1FF0, 0, 3, 0, 1, 15'h2010, 1, 1, 0));
    vecs.push_back(mk(0, 15'h1FF0, 0, 3, 0, 1, 15'h2008, 1, 1, 0));
    vecs.push_back(mk(0, 15'h1FF0, 0, 3, 0, 1, 15'h2000, 1, 1, 0));
    vecs.push_back(mk(0, 15'h1FF0, 0, 3, 0, 1, 15'h1FF8, 1, 1, 0));
    vecs.push_back(mk(0, 15'h1FF0, 0, 3, 0, 1, 15'h1FF0, 0, 1, 1));
    // boundaries: top of range, zero, shift clamp
    vecs.push_back(mk(1, 15'h7FF0, 0, 14, 0, 2, 15'h2000, 1, 0, 0));
    vecs.push_back(mk(0, 15'h7FF0, 0, 14, 0, 1, 15'h6000, 1, 1, 0));
    vecs.push_back(mk(0, 15'h7FF0, 0, 14, 0, 1, 15'h7FF0, 0, 1, 1));
    vecs.push_back(mk(0, 15'h7FFF, 0, 8, 0, 2, 15'h7FF0, 1, 0, 0));
    vecs.push_back(mk(0, 15'h7FFF, 0, 8, 0, 1, 15'h7FFF, 0, 1, 1));
    vecs.push_back(mk(0, 15'h0005, 0, 14, 0, 2, 15'h7FFF, 1, 0, 0));
    vecs.push_back(mk(0, 15'h0005, 0, 14, 0, 1, 15'h3FFF, 1, 1, 0));
    vecs.push_back(mk(0, 15'h0005, 0, 14, 0, 1, 15'h0005, 0, 1, 1));
    vecs.push_back(mk(0, 15'h0000, 0, 8, 0, 2, 15'h0005, 1, 0, 0));
    vecs.push_back(mk(0, 15'h0000, 0, 8, 0, 1, 15'h0000, 0, 1, 1));
    vecs.push_back(mk(0, 15'h7FFF, 0, 15, 0, 2, 15'h0000, 1, 0, 0));
    vecs.push_back(mk(0, 15'h7FFF, 0, 15, 0, 1, 15'h4000, 1, 1, 0));
    vecs.push_back(mk(0, 15'h7FFF, 0, 15, 0, 1, 15'h7FFF, 0, 1, 1));
    // hold mid-ramp keeps the prescaler count
    vecs.push_back(mk(1, 15'h2100, 2, 3, 0, 1, 15'h2000, 0, 0, 0));
    vecs.push_back(mk(0, 15'h2100, 2, 3, 0, 1, 15'h2000, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2100, 2, 3, 0, 2, 15'h2000, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2100, 2, 3, 0, 1, 15'h2008, 1, 1, 0));
    vecs.push_back(mk(0, 15'h2100, 2, 3, 0, 1, 15'h2008, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2100, 2, 3, 1, 20, 15'h2008, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2100, 2, 3, 0, 1, 15'h2008, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2100, 2, 3, 0, 1, 15'h2010, 1, 1, 0));
    // target returns to value mid-ramp: no strobe, back to idle
    vecs.push_back(mk(1, 15'h2100, 3, 3, 0, 1, 15'h2000, 0, 0, 0));
    vecs.push_back(mk(0, 15'h2100, 3, 3, 0, 1, 15'h2000, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2000, 3, 3, 0, 1, 15'h2000, 1, 0, 1));
    vecs.push_back(mk(0, 15'h2000, 3, 3, 0, 2, 15'h2000, 1, 0, 1));
    vecs.push_back(mk(0, 15'h2000, 3, 3, 0, 1, 15'h2000, 0, 0, 1));
    // target change under hold still enters ramp but does not step
    vecs.push_back(mk(1, 15'h2040, 0, 3, 1, 5, 15'h2000, 1, 0, 0));
    vecs.push_back(mk(0, 15'h2040, 0, 3, 0, 1, 15'h2008, 1, 1, 0));

    foreach (vecs[i]) begin
      target_in  = vecs[i].tgt;
      rate_div   = vecs[i].rd;
      step_shift = vecs[i].ss;
      hold       = vecs[i].h;
      if (vecs[i].rst) do_reset();
      for (int c = 0; c < vecs[i].n; c++) tick($sformatf("vec%0d_model", i));
      act = {value_out, upd_stb, busy, at_target};
      exp = {vecs[i].val, vecs[i].stb, vecs[i].bsy, vecs[i].at};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL vec%0d: got val=%h stb=%b busy=%b at=%b, want val=%h stb=%b busy=%b at=%b",
                 i, act[17:3], act[2], act[1], act[0], exp[17:3], exp[2], exp[1], exp[0]);
      end
    end

    // asynchronous reset mid-ramp, checked without any clock edge
    target_in  = 15'h2100;
    rate_div   = '0;
    step_shift = 4'd3;
    hold       = 1'b0;
    do_reset();
    for (int c = 0; c < 3; c++) tick("async_pre");
    @(posedge clk);
    model_clock(int'(target_in), int'(rate_div), int'(step_shift), hold);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({value_out, upd_stb, busy, at_target} !== {15'h2000, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset: got val=%h stb=%b busy=%b at=%b, want 2000/0/0/1",
               value_out, upd_stb, busy, at_target);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          target_in = 15'($urandom);
        end else begin
          nv = m_val + $urandom_range(0, 128) - 64;
          if (nv < 0) nv = 0;
          if (nv > 'h7FFF) nv = 'h7FFF;
          target_in = 15'(nv);
        end
        rate_div   = 16'($urandom_range(0, 3));
        step_shift = 4'($urandom_range(0, 15));
      end
      hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
